// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and types for the multu8 sharing arbiter.
package mult_share_pkg;

    localparam int unsigned DATA_W = 8;

    // Output buffer occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin arbiter with an optional burst lock.
// Build option: MULT_SHARE_LOCK_EN enables the lock logic; otherwise
// req_lock_i is ignored and the arbiter is pure round-robin.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid_i,
    input  logic [NUM_REQ-1:0]  req_lock_i,
    input  logic                can_accept_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_W-1:0]     gnt_idx_o,
    output logic                gnt_vld_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] rr_idx;
    logic            rr_found;
    logic [ID_W-1:0] sel_idx;
    logic            sel_found;

    // Circular priority search starting at the pointer
    always_comb begin
        int j;
        rr_found = 1'b0;
        rr_idx   = '0;
        j        = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            j = int'(ptr_q) + k;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (!rr_found && req_valid_i[ID_W'(j)]) begin
                rr_found = 1'b1;
                rr_idx   = ID_W'(j);
            end
        end
    end

`ifdef MULT_SHARE_LOCK_EN
    localparam int unsigned CNT_W = clog2(LOCK_MAX) + 1;

    logic             lock_vld_q, lock_vld_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_hold;

    // The owner keeps priority only while it still asks for the lock
    assign lock_hold = lock_vld_q & req_valid_i[owner_q] & req_lock_i[owner_q];

    // Locked owner overrides the round-robin winner
    always_comb begin
        if (lock_hold) begin
            sel_found = 1'b1;
            sel_idx   = owner_q;
        end else begin
            sel_found = rr_found;
            sel_idx   = rr_idx;
        end
    end

    // Lock bookkeeping: load on a locking grant, count down on locked grants,
    // release on exhaustion or when the owner lets go; stalls leave it alone
    always_comb begin
        lock_vld_d = lock_vld_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        if (gnt_vld_o) begin
            if (lock_hold) begin
                cnt_d      = cnt_q - CNT_W'(1);
                lock_vld_d = (cnt_q != CNT_W'(1));
            end else if (req_lock_i[sel_idx]) begin
                owner_d    = sel_idx;
                cnt_d      = CNT_W'(LOCK_MAX - 1);
                lock_vld_d = (LOCK_MAX > 1);
            end else begin
                lock_vld_d = 1'b0;
            end
        end else if (!lock_hold) begin
            lock_vld_d = 1'b0;
        end
    end

    // Lock state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld_q <= 1'b0;
            owner_q    <= '0;
            cnt_q      <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = (^req_lock_i) ^ (LOCK_MAX != 0);

    // Pure round-robin selection
    always_comb begin
        sel_found = rr_found;
        sel_idx   = rr_idx;
    end
`endif

    // One-hot grant, only when the output buffer can take a result
    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = sel_found & can_accept_i;
        gnt_idx_o = sel_idx;
        if (gnt_vld_o) begin
            gnt_o[sel_idx] = 1'b1;
        end
    end

    // Pointer moves past the winner on a grant, holds otherwise
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            if (sel_idx == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel_idx + ID_W'(1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/multu8.sv
// 8-bit unsigned multiplier, product truncated to 8 bits.
module multu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out
);

    assign out = a * b;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multu8 among NUM_REQ valid/ready requesters and returns the
// product with the requester id through a one-entry output buffer.
// Build option: MULT_SHARE_LOCK_EN enables burst locking in rr_arbiter.
//
// Output buffer states:
//   state | meaning
//   EMPTY | no result held; any valid request can be accepted
//   FULL  | result held on rsp_*; accept only if it drains this cycle
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]          req_lock,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_data
);

    buf_state_e          state_q, state_d;
    logic                can_accept;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_vld;
    logic [DATA_W-1:0]   mul_a, mul_b, mul_out;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W),
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_lock_i   (req_lock),
        .can_accept_i (can_accept),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx),
        .gnt_vld_o    (gnt_vld)
    );

    assign req_ready = gnt;

    // One-hot AND-OR mux of the granted operands
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                mul_a = mul_a | req_a[i*DATA_W +: DATA_W];
                mul_b = mul_b | req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    multu8 u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .out (mul_out)
    );

    // Buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer next state; a grant while full overwrites the drained entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (gnt_vld) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (gnt_vld) begin
                    state_d = FULL;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Buffer outputs; rst_n gating keeps req_ready low while in reset
    always_comb begin
        rsp_valid  = (state_q == FULL);
        can_accept = rst_n & ((state_q == EMPTY) | rsp_ready);
    end

    // Result capture on the grant edge
    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (gnt_vld) begin
            rsp_data_d = mul_out;
            rsp_id_d   = gnt_idx;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter (default or MULT_SHARE_LOCK_EN build).
module tb_mult_share_arbiter;

    localparam int NR   = 4;
    localparam int LMAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*8-1:0]   req_a;
    logic [NR*8-1:0]   req_b;
    logic [NR-1:0]     req_lock;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [7:0]        rsp_data;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .NUM_REQ  (NR),
        .ID_W     (2),
        .LOCK_MAX (LMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: next requester to consider, buffer contents, lock burst
    int m_ptr;
    bit m_full;
    int m_id;
    int m_data;
    bit m_lock;
    int m_owner;
    int m_left;
    int last_w;

    typedef struct packed {
        int id;
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t tbl [8];
    int   exp_seq [5];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int opnd(input logic [NR*8-1:0] bus, input int i);
        logic [7:0] v;
        v = bus[i*8 +: 8];
        return int'(v);
    endfunction

    function automatic bit owner_holds();
`ifdef MULT_SHARE_LOCK_EN
        return m_lock && req_valid[m_owner] && req_lock[m_owner];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pick();
        int j;
        if (owner_holds()) return m_owner;
        for (int k = 0; k < NR; k++) begin
            j = (m_ptr + k) % NR;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_id   = 0;
        m_data = 0;
        m_lock = 0;
        m_owner = 0;
        m_left = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic tick();
        int w;
        int exp_ready;
        bit holds;
        @(negedge clk);
        w = (!m_full || rsp_ready) ? pick() : -1;
        exp_ready = (w >= 0) ? (1 << w) : 0;
        holds = owner_holds();
        chk("req_ready", int'(req_ready), exp_ready);
        chk("rsp_valid", int'(rsp_valid), int'(m_full));
        if (m_full) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_data", int'(rsp_data), m_data);
        end
        @(posedge clk);
        if (w >= 0) begin
            m_full = 1;
            m_id   = w;
            m_data = (opnd(req_a, w) * opnd(req_b, w)) % 256;
            m_ptr  = (w + 1) % NR;
`ifdef MULT_SHARE_LOCK_EN
            if (holds) begin
                m_left--;
                if (m_left == 0) m_lock = 0;
            end else if (req_lock[w]) begin
                m_owner = w;
                m_left  = LMAX - 1;
                m_lock  = (m_left > 0);
            end else begin
                m_lock = 0;
            end
`endif
        end else begin
            if (rsp_ready) m_full = 0;
`ifdef MULT_SHARE_LOCK_EN
            if (!holds) m_lock = 0;
`endif
        end
        last_w = w;
        #1;
    endtask

    task automatic set_op(input int id, input int a, input int b);
        logic [7:0] av;
        logic [7:0] bv;
        av = 8'(a);
        bv = 8'(b);
        req_a[id*8 +: 8] = av;
        req_b[id*8 +: 8] = bv;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_lock  = '0;
        rsp_ready = 1'b0;
        #1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_data", int'(rsp_data), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        last_w    = -1;
        model_reset();

        tbl[0] = '{0, 65, 11, 203};
        tbl[1] = '{1, 66, 12, 24};
        tbl[2] = '{2, 67, 13, 103};
        tbl[3] = '{3, 68, 14, 184};
        tbl[4] = '{2, 255, 255, 1};
        tbl[5] = '{1, 0, 200, 0};
        tbl[6] = '{3, 16, 16, 0};
        tbl[7] = '{0, 15, 17, 255};

        #2;
        do_reset();

        // Single requester
        set_op(0, 64, 10);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("single_ready", int'(req_ready), 1);
        tick();
        chk("single_valid", int'(rsp_valid), 1);
        chk("single_id", int'(rsp_id), 0);
        chk("single_data", int'(rsp_data), 128);
        req_valid = '0;
        tick();

        // All four valid at once, each holds until granted
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(tbl[i].id, tbl[i].a, tbl[i].b);
            req_valid[tbl[i].id] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("batch_grant", last_w, tbl[i].id);
            chk("batch_id", int'(rsp_id), tbl[i].id);
            chk("batch_data", int'(rsp_data), tbl[i].exp);
            if (last_w >= 0) req_valid[last_w] = 1'b0;
        end
        tick();

        // Operand corner values, one requester at a time
        for (int i = 4; i < 8; i++) begin
            set_op(tbl[i].id, tbl[i].a, tbl[i].b);
            req_valid = '0;
            req_valid[tbl[i].id] = 1'b1;
            tick();
            chk("corner_id", int'(rsp_id), tbl[i].id);
            chk("corner_data", int'(rsp_data), tbl[i].exp);
        end
        req_valid = '0;
        tick();

        // Backpressure then release with no bubble
        do_reset();
        set_op(0, 64, 10);
        req_valid = 4'b0001;
        tick();
        chk("bp_first", int'(rsp_data), 128);
        req_valid = 4'b0010;
        set_op(1, 3, 5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", int'(req_ready), 0);
            tick();
            chk("bp_hold_data", int'(rsp_data), 128);
            chk("bp_hold_id", int'(rsp_id), 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(req_ready), 2);
        tick();
        chk("bp_next_valid", int'(rsp_valid), 1);
        chk("bp_next_id", int'(rsp_id), 1);
        chk("bp_next_data", int'(rsp_data), 15);
        req_valid = '0;
        tick();
        chk("bp_drained", int'(rsp_valid), 0);

        // Pointer wrap after a grant to the last requester
        do_reset();
        rsp_ready = 1'b1;
        set_op(3, 2, 3);
        req_valid = 4'b1000;
        tick();
        chk("wrap_grant3", last_w, 3);
        set_op(1, 7, 7);
        req_valid = 4'b1010;
        tick();
        chk("wrap_first", last_w, 1);
        chk("wrap_data", int'(rsp_data), 49);
        req_valid = 4'b1000;
        tick();
        chk("wrap_second", last_w, 3);
        req_valid = '0;
        tick();

        // Lock burst (or plain alternation without the lock build)
        do_reset();
        rsp_ready = 1'b1;
        set_op(1, 1, 1);
        req_valid = 4'b0010;
        tick();
        set_op(0, 5, 6);
        set_op(2, 9, 10);
        req_valid = 4'b0101;
        req_lock  = 4'b0100;
`ifdef MULT_SHARE_LOCK_EN
        exp_seq = '{2, 2, 2, 2, 0};
`else
        exp_seq = '{2, 0, 2, 0, 2};
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lock_seq", last_w, exp_seq[i]);
        end
        req_valid = '0;
        req_lock  = '0;
        tick();

        // Reset in the middle of a stalled result
        do_reset();
        set_op(1, 9, 9);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        chk("mid_pre_valid", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(rsp_valid), 0);
        chk("mid_rst_data", int'(rsp_data), 0);
        chk("mid_rst_id", int'(rsp_id), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        chk("mid_ptr_zero", int'(req_ready), 1);
        tick();
        chk("mid_first_grant", last_w, 0);
        req_valid = '0;
        tick();

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            req_valid = 4'($urandom);
            req_lock  = 4'($urandom);
            req_a     = 32'($urandom);
            req_b     = 32'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter that shares one existing multu8 instance (8-bit unsigned multiply, truncated 8-bit product) among NUM_REQ requesters, such as systolic-array PE columns or kernel-load logic.
- Each requester uses a valid/ready request interface.
- Grants at most one multiply per cycle.
- Registers the product with the requester id in a one-entry output buffer that has downstream backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).
- LOCK_MAX, 4, maximum consecutive locked grants (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant/accept; a handshake completes when valid and ready are both high.
- req_a  in  NUM_REQ*8  flat operand A; requester i uses bits [8i+7:8i].
- req_b  in  NUM_REQ*8  flat operand B, same packing as req_a.
- req_lock  in  NUM_REQ  burst-lock request; ignored unless MULT_SHARE_LOCK_EN is defined.
- rsp_valid  out  1  output buffer holds a result.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  ID_W  index of the requester that produced the result.
- rsp_data  out  8  a*b mod 256.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0.
  - Round-robin pointer = 0.
  - Lock counter = 0; lock owner invalid.
- Output buffer FSM:
  - States: EMPTY and FULL.
  - can_accept = EMPTY | (FULL & rsp_ready).
  - EMPTY→FULL on grant.
  - FULL→EMPTY on rsp_ready with no grant.
  - FULL→FULL on a simultaneous drain and grant: the buffer is overwritten with the new result, with no bubble.
- req_ready is combinational from req_valid, the pointer and can_accept.
  - At most one bit is high.
  - All bits are 0 when can_accept=0.
  - req_ready never depends on rsp_ready when the state is EMPTY.
- Arbitration:
  - Search starts at pointer p, ascending with wrap-around, and selects the first requester with req_valid set.
  - After a grant to requester i, p ← (i+1) mod NUM_REQ.
  - The pointer does not change on cycles with no grant.
- Datapath:
  - The granted operands are muxed into multu8.a/b.
  - multu8.out is captured into rsp_data at the grant edge, and the granted index is captured into rsp_id at the same edge.
  - Latency: a handshake at edge t gives rsp_valid=1 with the result after edge t.
  - Throughput: 1 result per cycle while rsp_ready is held high.
- Stability: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id hold constant.
- Requesters may drop req_valid without a handshake; no state changes as a result.
- Reset asserted mid-operation discards any buffered result immediately.

Optional Feature:
- Macro: MULT_SHARE_LOCK_EN.
- Defined:
  - A grant to i with req_lock[i]=1 makes i the lock owner and loads the counter with LOCK_MAX-1.
  - While the owner keeps req_valid and req_lock high and the counter is >0, the owner wins every accepting cycle; each such grant decrements the counter.
  - The lock releases when the counter reaches 0, or when the owner's req_lock or req_valid drops.
  - On release, normal round-robin resumes from owner+1.
  - Stalls (can_accept=0) do not decrement the counter.
- Undefined: req_lock is unused, and pure round-robin applies.

Decomposition:
- Package mult_share_pkg holds:
  - the DATA_W=8 constant;
  - the buffer state encoding (EMPTY=1'b0, FULL=1'b1);
  - the clog2 helper function.
- Natural sub-module: rr_arbiter, holding the pointer, the priority search and the optional lock logic. It outputs a one-hot grant and its index.
- The top level holds the operand mux, the multu8 instance and the output buffer.

Test Plan:
- Single requester: requester 0 presents a=64, b=10 with rsp_ready=1 → one cycle later rsp_valid=1, rsp_id=0, rsp_data=128.
- All 4 requesters valid simultaneously: a=65,66,67,68 and b=11,12,13,14, each requester holding its request until it is granted → grants in order 0,1,2,3, one per cycle; results 203, 24, 103, 184.
- Backpressure: hold rsp_ready=0 after the first result (64*10) → rsp_data stays 128 and req_ready is all zeros. Releasing rsp_ready → drain and next grant occur in the same cycle, with no bubble.
- Pointer wrap: a grant to requester 3 occurs, then requesters 1 and 3 are both valid → requester 1 is granted first (pointer=0).
- Reset mid-operation: assert rst_n=0 with rsp_valid=1 → rsp_valid=0, rsp_data=0 and pointer=0 immediately, with no clock edge required.
- With MULT_SHARE_LOCK_EN: requester 2 has req_lock=1 and stays valid while requester 0 is also valid → requester 2 is granted 4 consecutive times, then requester 0. Without the macro, grants alternate between 2 and 0.
